// File: rtl/inv_k2j_if.sv
// inv_k2j_if: target point in, joint angles out for the inv_k2j solver
interface inv_k2j_if;
  logic [31:0] in0;
  logic [31:0] in1;
  logic [31:0] out0;
  logic [31:0] out1;
  modport master (output in0, in1, input out0, out1);
  modport slave (input in0, in1, output out0, out1);
endinterface

// File: rtl/inv_k2j.sv
// inv_k2j: fixed-latency 40-cycle two-link inverse-kinematics solver, Q16.16
module inv_k2j_cordic (
  input  logic               clk,
  input  logic               rst,
  input  logic               ld,
  input  logic               en,
  input  logic        [3:0]  k,
  input  logic signed [33:0] xi,
  input  logic signed [33:0] yi,
  output logic signed [31:0] z
);
  localparam logic signed [31:0] HP = 32'sh0001921F;
  localparam logic [15:0] ROM [16] = '{
    16'd51472, 16'd30385, 16'd16055, 16'd8150, 16'd4091, 16'd2047, 16'd1024, 16'd512,
    16'd256, 16'd128, 16'd64, 16'd32, 16'd16, 16'd8, 16'd4, 16'd2
  };
  logic signed [33:0] x, y, xs, ys;
  logic signed [31:0] a;
  logic zf;
  always_comb begin
    xs = x >>> k;
    ys = y >>> k;
    a = {16'd0, ROM[k]};
  end
  always_ff @(posedge clk)
    if (!rst) begin
      x <= '0;
      y <= '0;
      z <= '0;
      zf <= 1'b0;
    end else if (ld) begin
      zf <= xi == '0 && yi == '0;
      x <= !xi[33] ? xi : yi[33] ? -yi : yi;
      y <= !xi[33] ? yi : yi[33] ? xi : -xi;
      z <= !xi[33] ? '0 : yi[33] ? -HP : HP;
    end else if (en && !zf) begin
      x <= y[33] ? x - ys : x + ys;
      y <= y[33] ? y + xs : y - xs;
      z <= y[33] ? z - a : z + a;
    end
endmodule

module inv_k2j (
  input logic      clk,
  input logic      rst,
  inv_k2j_if.slave bus
);
  logic [5:0] cnt;
  logic signed [31:0] x, y, c2, th1, th2, o0, o1, za, zb, zt;
  logic signed [63:0] xx, yy, cc;
  logic [63:0] sq;
  logic [47:0] r2;
  logic [16:0] v;
  logic [31:0] rad;
  logic [17:0] rem;
  logic [19:0] rn, tr;
  logic [15:0] root;
  logic ge;
  logic [3:0] ka, kb;
  logic signed [33:0] cx, bx, sx;
  always_comb begin
    xx = 64'(x) * 64'(x);
    yy = 64'(y) * 64'(y);
    sq = $unsigned(xx) + $unsigned(yy);
    cc = 64'(c2) * 64'(c2);
    v = 17'h10000 - 17'(cc >> 16);
    rn = {rem, rad[31:30]};
    tr = {2'b00, root, 2'b01};
    ge = rn >= tr;
    ka = 4'(cnt - 6'd2);
    kb = 4'(cnt - 6'd21);
    cx = {{2{c2[31]}}, c2};
    bx = cx + 34'sh10000;
    sx = {18'd0, root};
  end
  always_ff @(posedge clk)
    if (!rst) begin
      cnt <= '0;
      x <= '0;
      y <= '0;
      r2 <= '0;
      c2 <= '0;
      rad <= '0;
      rem <= '0;
      root <= '0;
      th1 <= '0;
      th2 <= '0;
      o0 <= '0;
      o1 <= '0;
    end else begin
      cnt <= cnt == 6'd39 ? '0 : cnt + 6'd1;
      if (cnt == 6'd0) begin
        x <= bus.in0;
        y <= bus.in1;
      end
      if (cnt == 6'd1) r2 <= 48'(sq >> 16);
      if (cnt == 6'd2) c2 <= r2 > 48'h10000 ? 32'sh10000 : $signed({14'd0, r2[16:0], 1'b0}) - 32'sh10000;
      if (cnt == 6'd3) begin
        rad <= v[16] ? '1 : {v[15:0], 16'h0};
        rem <= '0;
        root <= '0;
      end
      if (cnt >= 6'd4 && cnt <= 6'd19) begin
        rem <= ge ? 18'(rn - tr) : rn[17:0];
        root <= {root[14:0], ge};
        rad <= rad << 2;
      end
      if (cnt == 6'd37) begin
        th1 <= za - zb;
        th2 <= zt;
      end
      if (cnt == 6'd38) begin
        o0 <= th1;
        o1 <= th2;
      end
    end
  assign bus.out0 = o0;
  assign bus.out1 = o1;
  inv_k2j_cordic ua (
    .clk(clk), .rst(rst), .ld(cnt == 6'd1), .en(cnt >= 6'd2 && cnt <= 6'd17), .k(ka),
    .xi({{2{x[31]}}, x}), .yi({{2{y[31]}}, y}), .z(za)
  );
  inv_k2j_cordic ub (
    .clk(clk), .rst(rst), .ld(cnt == 6'd20), .en(cnt >= 6'd21 && cnt <= 6'd36), .k(kb),
    .xi(bx), .yi(sx), .z(zb)
  );
  inv_k2j_cordic ut (
    .clk(clk), .rst(rst), .ld(cnt == 6'd20), .en(cnt >= 6'd21 && cnt <= 6'd36), .k(kb),
    .xi(cx), .yi(sx), .z(zt)
  );
endmodule

// File: tb/tb_inv_k2j.sv
// tb_inv_k2j: scoreboard bench for inv_k2j with directed targets and mid-frame reset
module tb_inv_k2j;
  typedef struct {
    int frame;
    int e0;
    int e1;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  inv_k2j_if bus ();
  inv_k2j dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  exp_t q[$];
  exp_t e;
  int checks = 0;
  int failures = 0;
  int tcnt = 0;
  int fno = 0;
  int c = 0;
  int ec = 0;
  logic r;
  logic [31:0] p0 = '0;
  logic [31:0] p1 = '0;
  task automatic near(input string nm, input logic [31:0] act, input int want);
    int d;
    d = $signed(act) - want;
    checks++;
    if (d > 40 || d < -40) begin
      failures++;
      $display("FAIL %s: got %0d want %0d (+-40)", nm, $signed(act), want);
    end
  endtask
  task automatic same(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask
  task automatic wait_at(input int n);
    do @(negedge clk); while (tcnt != n);
  endtask
  task automatic apply(input logic [31:0] a, input logic [31:0] b, input int e0, input int e1);
    wait_at(10);
    bus.in0 = a;
    bus.in1 = b;
    q.push_back(exp_t'{fno + 1, e0, e1});
  endtask
  initial begin
    forever begin
      @(posedge clk);
      r = rst;
      ec = c;
      if (!r) c = 0;
      else begin
        if (c == 0) fno++;
        c = c == 39 ? 0 : c + 1;
      end
      tcnt = c;
      #1;
      if (!r) begin
        same("rst_out0", bus.out0, '0);
        same("rst_out1", bus.out1, '0);
      end else if (ec == 38) begin
        while (q.size() > 0 && q[0].frame < fno) begin
          e = q.pop_front();
          checks++;
          failures++;
          $display("FAIL missed_frame %0d: got no result want out0=%0d out1=%0d", e.frame, e.e0, e.e1);
        end
        if (q.size() > 0 && q[0].frame == fno) begin
          e = q.pop_front();
          near($sformatf("theta1_f%0d", fno), bus.out0, e.e0);
          near($sformatf("theta2_f%0d", fno), bus.out1, e.e1);
        end
      end else begin
        same("hold_out0", bus.out0, p0);
        same("hold_out1", bus.out1, p1);
      end
      p0 = bus.out0;
      p1 = bus.out1;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    bus.in0 = 32'h00010000;
    bus.in1 = 32'h00010000;
    q.push_back(exp_t'{1, 51472, 0});
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (80) @(negedge clk);
    apply(32'h00008000, 32'h00008000, 0, 102944);
    apply(32'h00000000, 32'h00000000, 0, 205887);
    apply(32'h00000000, 32'h00010000, 102944, 0);
    apply(32'hFFFF8000, 32'h00008000, 102944, 102944);
    apply(32'hFFFF8000, 32'hFFFF8000, -205887, 102944);
    apply(32'h00004CCC, 32'h00006666, -7858, 137258);
    apply(32'h00008000, 32'h00000000, -68629, 137258);
    apply(32'h00020000, 32'h00000000, 0, 0);
    apply(32'h00008000, 32'h00008000, 0, 102944);
    wait_at(10);
    wait_at(10);
    wait_at(20);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    q.push_back(exp_t'{fno + 1, 0, 102944});
    rst = 1'b1;
    repeat (85) @(negedge clk);
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      failures++;
      $display("FAIL leftover_frame %0d: got no result want out0=%0d out1=%0d", e.frame, e.e0, e.e1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
